// File: rtl/gate_example_pkg.sv
// rtl/gate_example_pkg.sv - shared constants for gate_example (default counter width, reset values)
package gate_example_pkg;

    // Default width of the e-rise event counter
    localparam int CNT_W_DEF = 8;

    // Reset values of the registered outputs and of the rise counter
    localparam logic E_RST   = 1'b0;
    localparam logic F_RST   = 1'b0;
    localparam int   CNT_RST = 0;

endpackage : gate_example_pkg

// File: rtl/gate_example_logic.sv
// rtl/gate_example_logic.sv - stateless AND-OR and 4-input odd-parity gate logic
module gate_example_logic (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e_nxt,
    output logic f_nxt
);

    // AND-OR term feeding the e register
    assign e_nxt = (a & b) | (c & d);

    // Odd parity of the four operands feeding the f register
    assign f_nxt = a ^ b ^ c ^ d;

endmodule : gate_example_logic

// File: rtl/gate_example.sv
// rtl/gate_example.sv - registered gate outputs e/f; optional e-rise counter under GATE_EXAMPLE_STATS_EN
module gate_example
    import gate_example_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             e,
`ifdef GATE_EXAMPLE_STATS_EN
    output logic [CNT_W-1:0] e_rise_cnt,
`endif
    output logic             f
);

    logic w_e_nxt;
    logic w_f_nxt;
    logic r_e;
    logic r_f;

    gate_example_logic u_logic (
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .e_nxt (w_e_nxt),
        .f_nxt (w_f_nxt)
    );

    // Output registers: inputs sampled on each rising edge, one-cycle latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e <= E_RST;
            r_f <= F_RST;
        end else begin
            r_e <= w_e_nxt;
            r_f <= w_f_nxt;
        end
    end

    assign e = r_e;
    assign f = r_f;

`ifdef GATE_EXAMPLE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_RST);

    logic             r_e_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;

    // A rise is registered e high while its previous value was low; the
    // post-reset load counts because r_e_prev resets to the same value as e
    assign w_rise = r_e & ~r_e_prev;

    // Previous-e tracker and saturating rise counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_prev <= E_RST;
            r_cnt    <= CNT_INIT;
        end else begin
            r_e_prev <= r_e;
            if (w_rise && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign e_rise_cnt = r_cnt;
`endif

endmodule : gate_example

// File: tb/tb_gate_example.sv
// tb/tb_gate_example.sv - directed self-checking bench for gate_example (counter checks under GATE_EXAMPLE_STATS_EN)
module tb_gate_example;

    logic clk;
    logic rst_n;
    logic a, b, c, d;
    logic e, f;
`ifdef GATE_EXAMPLE_STATS_EN
    logic [7:0] e_rise_cnt;
    logic       e_s, f_s;
    logic [1:0] e_rise_cnt_s;
`endif

    int n_total;
    int n_bad;

    // Hand-computed truth tables, bit index = {a,b,c,d}
    logic [15:0] e_tbl;
    logic [15:0] f_tbl;

    gate_example u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
`ifdef GATE_EXAMPLE_STATS_EN
        .e_rise_cnt (e_rise_cnt),
`endif
        .f          (f)
    );

`ifdef GATE_EXAMPLE_STATS_EN
    gate_example #(.CNT_W(2)) u_dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e_s),
        .e_rise_cnt (e_rise_cnt_s),
        .f          (f_s)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive operands at the falling edge, then step past the next rising edge
    task automatic step(input logic [3:0] abcd);
        @(negedge clk);
        {a, b, c, d} = abcd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout got=0 exp=1");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        e_tbl   = 16'hF888;
        f_tbl   = 16'h6996;
        rst_n   = 1'b0;
        {a, b, c, d} = 4'b1111;

        // Reset held low with all operands high
        #1;
        chk("rst_e_now", 32'(e), 32'd0);
        chk("rst_f_now", 32'(f), 32'd0);
`ifdef GATE_EXAMPLE_STATS_EN
        chk("rst_cnt_now", 32'(e_rise_cnt), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_e_held", 32'(e), 32'd0);
        chk("rst_f_held", 32'(f), 32'd0);
`ifdef GATE_EXAMPLE_STATS_EN
        chk("rst_cnt_held", 32'(e_rise_cnt), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Exhaustive 0000..1111, one per clock
        for (int i = 0; i < 16; i++) begin
            step(4'(i));
            chk($sformatf("exh_e_%0d", i), 32'(e), 32'(e_tbl[i]));
            chk($sformatf("exh_f_%0d", i), 32'(f), 32'(f_tbl[i]));
        end

        // Named spot vectors
        step(4'b1100);
        chk("v1100_e", 32'(e), 32'd1);
        chk("v1100_f", 32'(f), 32'd0);
        step(4'b0111);
        chk("v0111_e", 32'(e), 32'd1);
        chk("v0111_f", 32'(f), 32'd1);
        step(4'b1000);
        chk("v1000_e", 32'(e), 32'd0);
        chk("v1000_f", 32'(f), 32'd1);

        // Mid-cycle input change must not reach the outputs before the edge
        step(4'b0000);
        #2;
        {a, b, c, d} = 4'b0011;
        #1;
        chk("lat_e_mid", 32'(e), 32'd0);
        chk("lat_f_mid", 32'(f), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_e_edge", 32'(e), 32'd1);
        chk("lat_f_edge", 32'(f), 32'd0);

        // Asynchronous reset mid-cycle while e=1
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_e", 32'(e), 32'd0);
        chk("arst_f", 32'(f), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First post-reset edge loads the function of sampled inputs
        step(4'b1110);
        chk("post_rst_e", 32'(e), 32'd1);
        chk("post_rst_f", 32'(f), 32'd1);

`ifdef GATE_EXAMPLE_STATS_EN
        // That first load counted as a rise
        step(4'b1111);
        chk("first_rise_cnt", 32'(e_rise_cnt), 32'd1);

        // Rise counting and saturation
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1100);
            step(4'b0000);
        end
        step(4'b0000);
        step(4'b0000);
        chk("cnt_5", 32'(e_rise_cnt), 32'd5);
        chk("sat_5", 32'(e_rise_cnt_s), 32'd3);
        for (int i = 0; i < 5; i++) begin
            step(4'b1100);
            step(4'b0000);
        end
        step(4'b0000);
        chk("cnt_10", 32'(e_rise_cnt), 32'd10);
        chk("sat_10", 32'(e_rise_cnt_s), 32'd3);

        // e held high does not count
        step(4'b0011);
        step(4'b1111);
        step(4'b1100);
        step(4'b1100);
        chk("cnt_hold_hi", 32'(e_rise_cnt), 32'd11);

        // Reset mid-sequence discards a saturated count at once
        step(4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("sat_rst_now", 32'(e_rise_cnt_s), 32'd0);
        chk("cnt_rst_now", 32'(e_rise_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_gate_example

// File: doc/gate_example.md
GATE_EXAMPLE -- requirements
Module: gate_example

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the e-rise event counter.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have ports a, b, c, d, input, 1 bit each: gate operands, sampled on rising clk.
REQ-005 The block SHALL have port e, output, 1 bit: registered AND-OR result.
REQ-006 The block SHALL have port f, output, 1 bit: registered 4-input odd parity.
REQ-007 When GATE_EXAMPLE_STATS_EN is defined, the block SHALL have port e_rise_cnt, output, CNT_W bits: count of 0->1 transitions of e.

Function
REQ-008 The next value of e SHALL be (a AND b) OR (c AND d).
REQ-009 The next value of f SHALL be a XOR b XOR c XOR d.
REQ-010 e and f SHALL be registered, with latency exactly one clock: inputs sampled at rising edge N appear on e/f after edge N; no combinational input-to-output path.
REQ-011 Input changes between clock edges SHALL NOT affect e or f until the next rising edge.
REQ-012 e_rise_cnt SHALL increment by 1 on each edge where registered e goes 0->1.
REQ-013 e_rise_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-014 e_rise_cnt SHALL hold when e stays constant or falls 1->0.

Reset
REQ-015 Asserting rst_n low SHALL immediately force e=0, f=0 and e_rise_cnt=0, independent of clk.
REQ-016 While rst_n is low, all outputs SHALL hold at 0 regardless of inputs.
REQ-017 On the first rising edge after rst_n deasserts, e/f SHALL load the function of the inputs sampled at that edge.
REQ-018 A 0->1 transition of e caused by the first post-reset load SHALL count as a rise.
REQ-019 Reset asserted mid-operation SHALL discard all state, including a saturated counter.

Configuration
REQ-020 With GATE_EXAMPLE_STATS_EN defined, the block SHALL include the e-rise counter, the previous-e flop and the e_rise_cnt port.
REQ-021 Without GATE_EXAMPLE_STATS_EN, the block SHALL contain none of the counter logic, and e/f behaviour SHALL be identical to the enabled build.

Structure
REQ-022 Package gate_example_pkg SHALL hold the default CNT_W constant and the reset-value constants for e, f and the counter.
REQ-023 The combinational gate logic (REQ-008, REQ-009) SHALL be a sub-module gate_example_logic: inputs a..d, outputs e_nxt and f_nxt, no state.
REQ-024 gate_example SHALL hold all flops and the optional counter.

Verification
REQ-025 Reset: rst_n=0 with a=b=c=d=1 -> e=0, f=0, e_rise_cnt=0 at once and while held low.
REQ-026 Exhaustive: apply all 16 input combinations 0000..1111 (abcd), one per clock -> one edge later, e and f match REQ-008 and REQ-009; e.g. 1100 -> e=1,f=0; 0111 -> e=1,f=1; 1000 -> e=0,f=1.
REQ-027 Latency: change inputs mid-cycle from 0000 to 0011 -> e stays 0 until the next rising edge, then e=1, f=0.
REQ-028 Counter: toggle abcd between 0000 and 1100 each clock for 10 rises -> e_rise_cnt=10.
REQ-029 Saturation: CNT_W=2 with 5 rises -> e_rise_cnt=3; assert rst_n mid-sequence -> e_rise_cnt=0 immediately.
REQ-030 Build without GATE_EXAMPLE_STATS_EN -> REQ-026 passes unchanged and port e_rise_cnt is absent.
